// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: turns debounced pushbutton levels into a FWFT queue of
// PRESS / RELEASE / REPEAT events for the CPU. A shared tick drives per-button
// hold timers; a fixed-priority scheduler writes at most one event per cycle.
module btn_event_ctrl #(
  parameter int unsigned CLK_FREQUENCY_HZ  = 50_000_000,
  parameter int unsigned TICK_FREQUENCY_HZ = 1000,
  parameter int unsigned LONG_PRESS_TICKS  = 500,
  parameter int unsigned REPEAT_TICKS      = 100,
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter int unsigned SIMULATE          = 0,
  parameter int unsigned SIMULATE_TICK_CNT = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] pbtn_db,
  input  logic [5:0] repeat_en,
  input  logic       evt_rd,
  input  logic       clr_ovf,
  output logic       evt_valid,
  output logic [7:0] evt_data,
  output logic [4:0] evt_count,
  output logic       evt_ovf
);

  localparam int unsigned TOP_INT = (SIMULATE != 0) ? SIMULATE_TICK_CNT
                                    : (CLK_FREQUENCY_HZ / TICK_FREQUENCY_HZ) - 1;
  localparam logic [31:0] TICK_TOP = 32'(TOP_INT);
  localparam logic [16:0] LONG_V   = 17'(LONG_PRESS_TICKS);
  localparam logic [16:0] REP_V    = 17'(REPEAT_TICKS);
  localparam logic [4:0]  DEPTH_V  = 5'(FIFO_DEPTH);
  localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Tick generator
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic        tick_s;

  // Edge detection
  logic [5:0] prev_q;
  logic       arm_q;
  logic [5:0] rise_s, fall_s;

  // Hold timers; nrep is one bit wider so the advanced compare value cannot wrap
  logic [15:0] hold_q [6];
  logic [15:0] hold_d [6];
  logic [16:0] nrep_q [6];
  logic [16:0] nrep_d [6];
  logic [5:0]  active_q, active_d;
  logic [5:0]  rep_set_s;

  // Pending events and scheduler
  logic [5:0] press_q, press_d, rep_q, rep_d, rel_q, rel_d;
  logic [5:0] gnt_p_s, gnt_r_s, gnt_l_s;
  logic       found_s, merge_s;
  logic [7:0] wdata_s;

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          pop_s, push_s, drop_s, full_s;
  logic [7:0]    head_d;
  logic          ovf_q, ovf_d;

  // Output registers
  logic       evt_valid_q;
  logic [7:0] evt_data_q;
  logic [4:0] evt_count_q;

  // Tick counter next state and terminal-count pulse
  always_comb begin
    tick_s = (tick_cnt_q == TICK_TOP);
    if (tick_s) begin
      tick_cnt_d = 32'd0;
    end else begin
      tick_cnt_d = tick_cnt_q + 32'd1;
    end
  end

  // Edge detection, masked during the prev-load cycle after reset
  always_comb begin
    if (arm_q) begin
      rise_s = 6'b000000;
      fall_s = 6'b000000;
    end else begin
      rise_s = pbtn_db & ~prev_q;
      fall_s = ~pbtn_db & prev_q;
    end
  end

  // Per-button hold timer and repeat compare value
  always_comb begin
    hold_d    = hold_q;
    nrep_d    = nrep_q;
    active_d  = active_q;
    rep_set_s = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      if (rise_s[i]) begin
        hold_d[i]   = 16'd0;
        nrep_d[i]   = LONG_V;
        active_d[i] = 1'b1;
      end else if (fall_s[i]) begin
        active_d[i] = 1'b0;
      end else if (active_q[i] && tick_s && (hold_q[i] != 16'hFFFF)) begin
        hold_d[i] = hold_q[i] + 16'd1;
        // Advance the compare even when repeat is disabled so re-enabling keeps cadence
        if ({1'b0, hold_d[i]} == nrep_q[i]) begin
          nrep_d[i]    = nrep_q[i] + REP_V;
          rep_set_s[i] = repeat_en[i];
        end else begin
          nrep_d[i] = nrep_q[i];
        end
      end else begin
        hold_d[i] = hold_q[i];
      end
    end
  end

  // Fixed-priority grant: lowest button first, PRESS > REPEAT > RELEASE
  always_comb begin
    found_s = 1'b0;
    gnt_p_s = 6'b000000;
    gnt_r_s = 6'b000000;
    gnt_l_s = 6'b000000;
    wdata_s = 8'h00;
    for (int i = 0; i < 6; i++) begin
      if (!found_s) begin
        if (press_q[i]) begin
          gnt_p_s[i] = 1'b1;
          found_s    = 1'b1;
          wdata_s    = {2'b01, 3'b000, 3'(i)};
        end else if (rep_q[i]) begin
          gnt_r_s[i] = 1'b1;
          found_s    = 1'b1;
          wdata_s    = {2'b11, 3'b000, 3'(i)};
        end else if (rel_q[i]) begin
          gnt_l_s[i] = 1'b1;
          found_s    = 1'b1;
          wdata_s    = {2'b10, 3'b000, 3'(i)};
        end else begin
          found_s = 1'b0;
        end
      end else begin
        found_s = 1'b1;
      end
    end
  end

  // Pending bits: granted bits clear, new events set, re-set while pending merges
  always_comb begin
    press_d = (press_q & ~gnt_p_s) | rise_s;
    rep_d   = (rep_q & ~gnt_r_s) | rep_set_s;
    rel_d   = (rel_q & ~gnt_l_s) | fall_s;
    merge_s = |((press_q & ~gnt_p_s & rise_s) |
                (rep_q & ~gnt_r_s & rep_set_s) |
                (rel_q & ~gnt_l_s & fall_s));
  end

  // FIFO control, occupancy and next head word for the registered FWFT output
  always_comb begin
    pop_s    = evt_rd & (count_q != 5'd0);
    full_s   = (count_q == DEPTH_V);
    push_s   = found_s & (~full_s | pop_s);
    drop_s   = found_s & full_s & ~pop_s;
    rd_ptr_d = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    if (count_d == 5'd0) begin
      head_d = 8'h00;
    end else if ((count_q == 5'd0) || (pop_s && (count_q == 5'd1))) begin
      head_d = wdata_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    if (drop_s || merge_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q  <= 32'd0;
      prev_q      <= 6'b000000;
      arm_q       <= 1'b1;
      active_q    <= 6'b000000;
      press_q     <= 6'b000000;
      rep_q       <= 6'b000000;
      rel_q       <= 6'b000000;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 5'd0;
      ovf_q       <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_data_q  <= 8'h00;
      evt_count_q <= 5'd0;
      for (int i = 0; i < 6; i++) begin
        hold_q[i] <= 16'd0;
        nrep_q[i] <= LONG_V;
      end
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      prev_q      <= pbtn_db;
      arm_q       <= 1'b0;
      active_q    <= active_d;
      press_q     <= press_d;
      rep_q       <= rep_d;
      rel_q       <= rel_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      evt_valid_q <= (count_d != 5'd0);
      evt_data_q  <= head_d;
      evt_count_q <= count_d;
      for (int i = 0; i < 6; i++) begin
        hold_q[i] <= hold_d[i];
        nrep_q[i] <= nrep_d[i];
      end
    end
  end

  // FIFO storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_s;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_data  = evt_data_q;
  assign evt_count = evt_count_q;
  assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with a 6-clock tick and short hold thresholds.
module tb_btn_event_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] pbtn_db;
  logic [5:0] repeat_en;
  logic       evt_rd;
  logic       clr_ovf;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic [4:0] evt_count;
  logic       evt_ovf;

  int total = 0;
  int bad   = 0;

  logic [7:0] ev_d [8];
  int         ev_t [8];
  int         nev;
  logic [7:0] exp_drain [8];

  btn_event_ctrl #(
    .CLK_FREQUENCY_HZ (50_000_000),
    .TICK_FREQUENCY_HZ(1000),
    .LONG_PRESS_TICKS (4),
    .REPEAT_TICKS     (2),
    .FIFO_DEPTH       (8),
    .SIMULATE         (1),
    .SIMULATE_TICK_CNT(5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pbtn_db  (pbtn_db),
    .repeat_en(repeat_en),
    .evt_rd   (evt_rd),
    .clr_ovf  (clr_ovf),
    .evt_valid(evt_valid),
    .evt_data (evt_data),
    .evt_count(evt_count),
    .evt_ovf  (evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop1();
    evt_rd = 1'b1;
    @(negedge clk);
    evt_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pbtn_db = 6'h01; repeat_en = 6'h00; evt_rd = 1'b0; clr_ovf = 1'b0;

    // Reset state with button 0 held through reset
    wait_neg(3);
    chk("rst_valid", 16'(evt_valid), 16'h0);
    chk("rst_data",  16'(evt_data),  16'h00);
    chk("rst_count", 16'(evt_count), 16'h0);
    chk("rst_ovf",   16'(evt_ovf),   16'h0);
    reset = 1'b0;
    wait_neg(20);
    chk("held_thru_rst_valid", 16'(evt_valid), 16'h0);
    chk("held_thru_rst_count", 16'(evt_count), 16'h0);
    chk("held_thru_rst_ovf",   16'(evt_ovf),   16'h0);

    // Releasing the held button still reports RELEASE after 2 cycles
    pbtn_db = 6'h00;
    wait_neg(1);
    chk("rel0_lat1_valid", 16'(evt_valid), 16'h0);
    wait_neg(1);
    chk("rel0_valid", 16'(evt_valid), 16'h1);
    chk("rel0_data",  16'(evt_data),  16'h80);
    pop1();
    chk("rel0_popped_count", 16'(evt_count), 16'h0);
    chk("rel0_popped_data",  16'(evt_data),  16'h00);

    // Buttons 5 and 1 rise together: 41 then 45 on consecutive cycles
    pbtn_db = 6'h22;
    wait_neg(2);
    chk("sim_c1_count", 16'(evt_count), 16'h1);
    chk("sim_c1_data",  16'(evt_data),  16'h41);
    wait_neg(1);
    chk("sim_c2_count", 16'(evt_count), 16'h2);
    chk("sim_c2_data",  16'(evt_data),  16'h41);
    pop1();
    chk("sim_pop1_data",  16'(evt_data),  16'h45);
    chk("sim_pop1_count", 16'(evt_count), 16'h1);
    pop1();
    chk("sim_pop2_valid", 16'(evt_valid), 16'h0);
    pbtn_db = 6'h00;
    wait_neg(3);
    chk("sim_rel_count", 16'(evt_count), 16'h2);
    chk("sim_rel_data",  16'(evt_data),  16'h81);
    pop1();
    chk("sim_rel2_data", 16'(evt_data),  16'h85);
    pop1();
    chk("sim_rel_empty", 16'(evt_count), 16'h0);

    // Auto-repeat on button 3: PRESS, REPEAT at ticks 4,6,8,10, RELEASE
    nev = 0;
    repeat_en = 6'h08;
    pbtn_db   = 6'h08;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      evt_rd = 1'b0;
      if (evt_valid) begin
        if (nev < 8) begin
          ev_d[nev] = evt_data;
          ev_t[nev] = n;
        end
        nev++;
        evt_rd = 1'b1;
      end
      if (n == 66) pbtn_db = 6'h00;
    end
    @(negedge clk);
    evt_rd = 1'b0;
    repeat_en = 6'h00;
    chk("rep_nevents", 16'(nev), 16'd6);
    chk("rep_ev0", 16'(ev_d[0]), 16'h43);
    chk("rep_ev1", 16'(ev_d[1]), 16'hC3);
    chk("rep_ev2", 16'(ev_d[2]), 16'hC3);
    chk("rep_ev3", 16'(ev_d[3]), 16'hC3);
    chk("rep_ev4", 16'(ev_d[4]), 16'hC3);
    chk("rep_ev5", 16'(ev_d[5]), 16'h83);
    chk("rep_t_press", 16'(ev_t[0]), 16'd2);
    chk("rep_t_first_in_window", 16'((ev_t[1] - ev_t[0] >= 19) && (ev_t[1] - ev_t[0] <= 24)), 16'h1);
    chk("rep_gap12", 16'(ev_t[2] - ev_t[1]), 16'd12);
    chk("rep_gap23", 16'(ev_t[3] - ev_t[2]), 16'd12);
    chk("rep_gap34", 16'(ev_t[4] - ev_t[3]), 16'd12);
    chk("rep_t_release", 16'(ev_t[5]), 16'd68);

    // Overflow: 6 presses plus 3 releases into 8 entries, ninth dropped
    pbtn_db = 6'h3F;
    wait_neg(10);
    chk("ovf_6press_count", 16'(evt_count), 16'h6);
    pbtn_db = 6'h38;
    wait_neg(6);
    chk("ovf_count", 16'(evt_count), 16'h8);
    chk("ovf_flag",  16'(evt_ovf),   16'h1);
    chk("ovf_head",  16'(evt_data),  16'h40);
    clr_ovf = 1'b1;
    wait_neg(1);
    clr_ovf = 1'b0;
    chk("ovf_cleared", 16'(evt_ovf), 16'h0);

    // Full FIFO, new PRESS granted in the same cycle as a pop: no drop
    pbtn_db = 6'h39;
    wait_neg(1);
    chk("fullpop_head_before", 16'(evt_data), 16'h40);
    evt_rd = 1'b1;
    wait_neg(1);
    evt_rd = 1'b0;
    chk("fullpop_count", 16'(evt_count), 16'h8);
    chk("fullpop_ovf",   16'(evt_ovf),   16'h0);
    exp_drain[0] = 8'h41; exp_drain[1] = 8'h42; exp_drain[2] = 8'h43; exp_drain[3] = 8'h44;
    exp_drain[4] = 8'h45; exp_drain[5] = 8'h80; exp_drain[6] = 8'h81; exp_drain[7] = 8'h40;
    evt_rd = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d", k), 16'(evt_data), 16'(exp_drain[k]));
      @(negedge clk);
    end
    evt_rd = 1'b0;
    chk("drain_empty_count", 16'(evt_count), 16'h0);
    chk("drain_empty_valid", 16'(evt_valid), 16'h0);

    // Pop on empty FIFO has no effect
    pop1();
    chk("empty_pop_count", 16'(evt_count), 16'h0);
    chk("empty_pop_data",  16'(evt_data),  16'h00);

    // Reset mid-operation discards queued events
    pbtn_db = 6'h01;
    wait_neg(6);
    chk("preq_count", 16'(evt_count), 16'h3);
    chk("preq_head",  16'(evt_data),  16'h83);
    reset = 1'b1;
    wait_neg(1);
    chk("midrst_count", 16'(evt_count), 16'h0);
    chk("midrst_valid", 16'(evt_valid), 16'h0);
    chk("midrst_data",  16'(evt_data),  16'h00);
    reset = 1'b0;
    wait_neg(20);
    chk("postrst_count", 16'(evt_count), 16'h0);
    chk("postrst_ovf",   16'(evt_ovf),   16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
